uart_fifo_sync: RTL
===================

# uart_fifo_sync

Single-clock, parametrised FIFO for the UART transmit and receive data paths. It replaces the fixed 256x8 hard-macro FIFO with a portable register/RAM-inferred buffer. Data width, depth and almost-empty threshold are set by parameters; the almost-full threshold is a run-time input. It adds an occupancy count, a synchronous flush and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 8, width of DI/DO in bits
- DEPTH, 256, number of entries; power of two, 4..1024
- AW, $clog2(DEPTH), address width; derived, never overridden
- AE_LEVEL, 4, AEMPTY asserts when COUNT <= AE_LEVEL; range 0..DEPTH

- CLOCK  in  1  sole clock; all state updates on its rising edge
- RESET  in  1  asynchronous, active-high reset
- CLEAR  in  1  synchronous flush, active-high
- DI  in  DATA_WIDTH  write data
- WRB  in  1  write strobe, active-low
- RDB  in  1  read strobe, active-low
- LEVEL  in  AW+1  almost-full threshold; quasi-static
- DO  out  DATA_WIDTH  registered read data
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- AFULL  out  1  COUNT >= LEVEL
- AEMPTY  out  1  COUNT <= AE_LEVEL
- COUNT  out  AW+1  current occupancy, 0..DEPTH
- OVERFLOW  out  1  sticky flag: write attempted while FULL
- UNDERFLOW  out  1  sticky flag: read attempted while EMPTY

## Operation
- State:
  - storage array DEPTH x DATA_WIDTH
  - write pointer WP and read pointer RP, each AW bits; each wraps DEPTH-1 -> 0
  - COUNT register, AW+1 bits
  - DO register
  - two sticky error bits
- Write accept: WRB=0 and FULL=0. DI is stored at WP, then WP increments.
- Read accept: RDB=0 and EMPTY=0. The entry at RP is loaded into DO, then RP increments.
- Acceptance uses flag values sampled before the edge:
  - FULL with WRB=0 and RDB=0: the read is accepted, the write is rejected and OVERFLOW is set. COUNT becomes DEPTH-1.
  - EMPTY with WRB=0 and RDB=0: the write is accepted, the read is rejected and UNDERFLOW is set. COUNT becomes 1. DO holds. There is no fall-through.
  - Neither flag set, both strobes active: both are accepted and COUNT is unchanged.
- COUNT changes by +1 (write only), -1 (read only) or 0. It never exceeds DEPTH and never goes below 0.
- Flags are pure decodes of registered COUNT. They carry no extra latency beyond COUNT.
- LEVEL behaviour:
  - LEVEL=0: AFULL is constantly 1.
  - LEVEL>DEPTH: AFULL is never set.
  - LEVEL changes take effect combinationally.
- DO holds its value on every cycle without an accepted read.
- Data order is strictly first-in first-out. The output is bit-exact across pointer wrap.
- CLEAR=1 has priority over read and write. On that edge, CLEAR sets:
  - WP, RP and COUNT to 0
  - OVERFLOW and UNDERFLOW to 0
  - DO to 0

  Strobes on the same cycle are ignored and do not set the error flags.
- OVERFLOW and UNDERFLOW are cleared only by RESET or CLEAR.
- Storage contents are not reset. The pointers alone define validity.

## Timing
- Reset values, asserted asynchronously:
  - DO=0, COUNT=0
  - EMPTY=1, AEMPTY=1 (AE_LEVEL >= 0), FULL=0
  - AFULL=1 only if LEVEL=0
  - OVERFLOW=0, UNDERFLOW=0
- Reset removal is synchronous to CLOCK. The first strobe is honoured on the first rising edge after RESET deasserts.
- Reset asserted mid-operation discards all contents immediately. No partial write completes.
- Write-to-flag latency is 1: a write at edge N updates COUNT, EMPTY, AEMPTY, AFULL and FULL after edge N.
- Read latency is 1: DO is valid after the edge that accepts the read, the same edge that decrements COUNT.
- Write-to-read turnaround: a word written at edge N can be read at edge N+1 and appears on DO after N+1.
- Back-to-back reads and writes sustain one word per cycle each, indefinitely.
- There is no combinational path from DI, WRB or RDB to any output. LEVEL feeds AFULL combinationally.

## Test plan
- Reset and basic flags (DEPTH=16, AE_LEVEL=4, LEVEL=12):
  - Stimulus: release RESET, write 0x01..0x10 on consecutive cycles.
  - Response: EMPTY drops after the first write. AEMPTY drops when COUNT=5. AFULL rises when COUNT=12. FULL rises when COUNT=16.
- Overflow and ordering:
  - Stimulus: while FULL, pulse WRB with DI=0xAA, then read 16 words.
  - Response: OVERFLOW=1 and COUNT stays 16. DO reads 0x01..0x10 in order with no 0xAA, and EMPTY=1 after the last read.
- Simultaneous strobes at the boundaries:
  - Stimulus: when EMPTY, WRB=RDB=0 with DI=0x55.
  - Response: COUNT=1, UNDERFLOW=1, DO unchanged.
  - Stimulus: when FULL, both strobes active.
  - Response: COUNT=15, OVERFLOW=1, DO = oldest word.
- Wrap-around streaming:
  - Stimulus: 100 cycles of concurrent write and read at COUNT=8, with incrementing data.
  - Response: COUNT stays 8 throughout. DO sequence is exact across pointer wrap.
- CLEAR priority:
  - Stimulus: with COUNT=7 and OVERFLOW=1, assert CLEAR together with WRB=0 and RDB=0.
  - Response: next cycle COUNT=0, EMPTY=1, DO=0, both error flags 0.
- Asynchronous reset mid-stream:
  - Stimulus: assert RESET between clock edges during a burst.
  - Response: outputs reach their reset values without a clock edge. The first post-reset read with no prior write sets UNDERFLOW.

Source files
------------

// File: rtl/uart_fifo_sync.sv
// Single-clock parametrised FIFO for the UART data paths: registered read data,
// occupancy count, synchronous flush and sticky overflow/underflow flags.
module uart_fifo_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int AW         = $clog2(DEPTH),
  parameter int AE_LEVEL   = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  CLEAR,
  input  logic [DATA_WIDTH-1:0] DI,
  input  logic                  WRB,
  input  logic                  RDB,
  input  logic [AW:0]           LEVEL,
  output logic [DATA_WIDTH-1:0] DO,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY,
  output logic [AW:0]           COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode the registered count only; LEVEL is the sole combinational input.
  always_comb begin
    FULL   = (COUNT == DEPTH_C);
    EMPTY  = (COUNT == '0);
    AFULL  = (COUNT >= LEVEL);
    AEMPTY = (COUNT <= AE_C);
  end

  always_comb begin
    wr_req = ~WRB & ~CLEAR;
    rd_req = ~RDB & ~CLEAR;
    wr_acc = wr_req & ~FULL;
    rd_acc = rd_req & ~EMPTY;
  end

  // Storage is not reset; RESET only blocks a write on the edge it overlaps.
  always_ff @(posedge CLOCK) begin
    if (wr_acc && !RESET)
      mem[wp] <= DI;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wp        <= '0;
      rp        <= '0;
      COUNT     <= '0;
      DO        <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else if (CLEAR) begin
      wp        <= '0;
      rp        <= '0;
      COUNT     <= '0;
      DO        <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (wr_acc)
        wp <= wp + 1'b1;
      if (rd_acc) begin
        DO <= mem[rp];
        rp <= rp + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   COUNT <= COUNT + 1'b1;
        2'b01:   COUNT <= COUNT - 1'b1;
        default: COUNT <= COUNT;
      endcase
      if (wr_req && FULL)
        OVERFLOW <= 1'b1;
      if (rd_req && EMPTY)
        UNDERFLOW <= 1'b1;
    end
  end

endmodule
